ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Parametrised N-master arbiter for the single-port unified RAM. It generalises the fixed boot-loader/core 2:1 select into N requesters with a valid/ack handshake. Arbitration is either fixed-priority or round-robin. An optional force-owner override reproduces the boot handover. Read data is returned to the originating master after the RAM's read latency, tracked by a tagged pipeline. It sits between the boot loader, core fetch/data ports and debug agents, and the ram instance, in the top level.

Parameters:
N_MASTERS, 2, number of requesting ports (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8
MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin
READ_LATENCY, 1, cycles from RAM read request to valid read data (1..4)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
clk_en  in  1  clock enable; state advances only when high
i_force_en  in  1  restrict grants to master i_force_sel
i_force_sel  in  $clog2(N_MASTERS) (min 1)  forced owner index
i_req  in  N_MASTERS  per-master request valid; held until ack
i_we  in  N_MASTERS  per-master: 1 = write, 0 = read
i_be  in  N_MASTERS*BE_W  per-master byte enables, master k at slice k
i_addr  in  N_MASTERS*ADDR_W  per-master addresses
i_wdata  in  N_MASTERS*DATA_W  per-master write data
o_ack  out  N_MASTERS  one-hot request accepted this cycle
o_rvalid  out  N_MASTERS  one-hot read data valid for master k
o_rdata  out  DATA_W  shared read data bus
o_ram_read_req  out  1  RAM read strobe
o_ram_read_addr  out  ADDR_W  RAM read address
i_ram_read_data  in  DATA_W  RAM read data
o_ram_write_enable  out  1  RAM write strobe
o_ram_byte_enable  out  BE_W  RAM byte enables
o_ram_write_addr  out  ADDR_W  RAM write address
o_ram_write_data  out  DATA_W  RAM write data

Behaviour:
- Reset (rst high at posedge): rr pointer=0, read tag pipeline cleared. o_rvalid=0 the following cycle; in-flight reads are dropped and never return.
- Eligible set E = i_req, masked to bit i_force_sel when i_force_en=1. A forced index >= N_MASTERS gives E=0.
- Grant, combinational: MODE 0 picks the lowest set bit of E. MODE 1 picks the first set bit at or after the pointer, searching with wrap N_MASTERS-1 -> 0.
- o_ack = grant & {N{clk_en}}, at most one bit set. A request is accepted only in a cycle where o_ack is high. Masters hold req/we/be/addr/wdata stable until acked.
- RAM command is combinational from the granted master, valid only when the ack is nonzero.
  - Write: o_ram_write_enable=1, with be/addr/wdata.
  - Read: o_ram_read_req=1, with addr.
  - With no ack, both strobes are 0. The address/data buses then show master 0's fields; consumers ignore them.
- RR pointer: on an accepted request from master g, pointer <= (g+1) mod N_MASTERS. Otherwise it holds. The pointer is also updated in forced mode. MODE 0 ignores the pointer.
- Read tracking: a shift register of depth READ_LATENCY holds {valid, index}. It shifts only when clk_en=1.
  - An accepted read enters stage 0.
  - o_rvalid = onehot(tail.index) when tail.valid=1 and clk_en=1.
  - o_rdata = i_ram_read_data, passed through combinationally.
- clk_en low: no acks, no strobes, pipeline and pointer frozen, o_rvalid=0.
- Throughput: one access per enabled cycle. Back-to-back reads from different masters return in acceptance order.
- N_MASTERS=1: the grant is i_req[0], and the pointer is a constant 0.
- Simultaneous force change and request: evaluated combinationally in that cycle. Reads already in flight still return to their original master.

Decomposition:
- Package ram_arb_pkg:
  - arb_mode_e enum (ARB_FIXED=0, ARB_RR=1)
  - MAX_MASTERS=8, MAX_READ_LATENCY=4
  - rd_tag_t struct {valid, idx[2:0]}
- Sub-module rr_arbiter (N, MODE): request vector plus pointer in; one-hot grant and encoded index out. Purely combinational. The pointer register lives in ram_arbiter.

Test Plan:
1. MODE=1, N=3, i_req=3'b111 held for 6 cycles, all writes -> o_ack sequence 001,010,100,001,010,100. RAM write_addr follows each master's address.
2. MODE=0, N=3, i_req=3'b110 for 3 cycles -> o_ack=010 every cycle; master 2 is starved.
3. READ_LATENCY=2, reads acked from m0 (addr 0x10), then m1 (addr 0x20), RAM model returns addr+0x1000 -> o_rvalid=001 with rdata=0x1010 two cycles after the first ack, then 010 with rdata=0x1020.
4. i_force_en=1, i_force_sel=1, i_req=2'b11 -> only o_ack=10. Drop force -> RR resumes from pointer 0 with ack 01.
5. Read accepted, then rst asserted the next cycle -> no o_rvalid ever emitted; pointer returns to 0.
6. clk_en toggled 1,0,1 during a READ_LATENCY=3 read -> o_rvalid appears after 3 enabled cycles (4 clocks). No ack while clk_en=0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared arbitration mode enum, size limits and read-tag record for ram_arbiter
package ram_arb_pkg;
    typedef enum logic {ARB_FIXED = 1'b0, ARB_RR = 1'b1} arb_mode_e;
    localparam int MAX_MASTERS = 8;
    localparam int MAX_READ_LATENCY = 4;
    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } rd_tag_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational fixed-priority / round-robin pick; req+ptr in, one-hot grant and index out
module rr_arbiter import ram_arb_pkg::*; #(
    parameter int N = 2,
    parameter int MODE = 1,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);
    function automatic int slot(input int p, input int k);
        return (MODE == int'(ARB_RR)) ? (p + k) % N : k;
    endfunction

    always_comb begin
        grant = '0;
        idx = '0;
        for (int k = N - 1; k >= 0; k--)
            if (req[slot(int'(ptr), k)]) begin
                grant = N'(1) << slot(int'(ptr), k);
                idx = IW'(slot(int'(ptr), k));
            end
    end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: N-master arbiter onto single-port RAM; clk/rst/clk_en, force override, per-master req/we/be/addr/wdata in, ack/rvalid/rdata out, RAM read/write command out
module ram_arbiter import ram_arb_pkg::*; #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int MODE = 1,
    parameter int READ_LATENCY = 1,
    localparam int IW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clk_en,
    input  logic                           i_force_en,
    input  logic [IW-1:0]                  i_force_sel,
    input  logic [N_MASTERS-1:0]           i_req,
    input  logic [N_MASTERS-1:0]           i_we,
    input  logic [N_MASTERS*DATA_W/8-1:0]  i_be,
    input  logic [N_MASTERS*ADDR_W-1:0]    i_addr,
    input  logic [N_MASTERS*DATA_W-1:0]    i_wdata,
    output logic [N_MASTERS-1:0]           o_ack,
    output logic [N_MASTERS-1:0]           o_rvalid,
    output logic [DATA_W-1:0]              o_rdata,
    output logic                           o_ram_read_req,
    output logic [ADDR_W-1:0]              o_ram_read_addr,
    input  logic [DATA_W-1:0]              i_ram_read_data,
    output logic                           o_ram_write_enable,
    output logic [DATA_W/8-1:0]            o_ram_byte_enable,
    output logic [ADDR_W-1:0]              o_ram_write_addr,
    output logic [DATA_W-1:0]              o_ram_write_data
);
    logic [N_MASTERS-1:0] elig, grant;
    logic [IW-1:0] gidx, sel, ptr;
    logic acc, rd;
    logic [ADDR_W-1:0] addr_a [N_MASTERS];
    logic [DATA_W-1:0] wdata_a [N_MASTERS];
    logic [DATA_W/8-1:0] be_a [N_MASTERS];
    rd_tag_t pipe [READ_LATENCY];
    rd_tag_t tail;

    for (genvar k = 0; k < N_MASTERS; k++) begin : g_m
        assign addr_a[k] = i_addr[k*ADDR_W +: ADDR_W];
        assign wdata_a[k] = i_wdata[k*DATA_W +: DATA_W];
        assign be_a[k] = i_be[k*(DATA_W/8) +: DATA_W/8];
        assign elig[k] = i_req[k] & (~i_force_en | (i_force_sel == IW'(k)));
    end

    rr_arbiter #(.N(N_MASTERS), .MODE(MODE)) u_arb (
        .req(elig),
        .ptr(ptr),
        .grant(grant),
        .idx(gidx)
    );

    assign o_ack = grant & {N_MASTERS{clk_en}};
    assign acc = |o_ack;
    assign sel = acc ? gidx : '0;
    assign rd = acc & ~i_we[sel];
    assign o_ram_read_req = rd;
    assign o_ram_write_enable = acc & i_we[sel];
    assign o_ram_read_addr = addr_a[sel];
    assign o_ram_write_addr = addr_a[sel];
    assign o_ram_write_data = wdata_a[sel];
    assign o_ram_byte_enable = be_a[sel];
    assign tail = pipe[READ_LATENCY-1];
    assign o_rvalid = (tail.valid && clk_en) ? N_MASTERS'(1) << tail.idx : '0;
    assign o_rdata = i_ram_read_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
            for (int i = 0; i < READ_LATENCY; i++) pipe[i] <= '0;
        end else if (clk_en) begin
            if (acc) ptr <= (gidx == IW'(N_MASTERS - 1)) ? '0 : gidx + 1'b1;
            pipe[0] <= '{valid: rd, idx: 3'(sel)};
            for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: table-driven and directed checks of round-robin (a) and fixed-priority (b) ram_arbiter instances
module tb_ram_arbiter;
    logic clk = 0, rst = 1, clk_en = 1, force_en = 0;
    logic [1:0] force_sel = 0;
    logic [2:0] req = 0, we = 0;
    logic [31:0] ma [3];
    logic [95:0] addr_bus, wdata_bus;
    logic [11:0] be_bus = 12'hfff;
    int total = 0, bad = 0;

    logic [2:0] a_ack, a_rv, b_ack, b_rv;
    logic [31:0] a_rdata, a_raddr, a_waddr, a_wdata, a_rdin, b_rdata, b_raddr, b_waddr, b_wdata, b_rdin;
    logic a_rreq, a_wen, b_rreq, b_wen;
    logic [3:0] a_be, b_be;
    logic [31:0] ra [2];
    logic [31:0] rb [3];

    assign addr_bus = {ma[2], ma[1], ma[0]};
    assign wdata_bus = {32'hc2, 32'hc1, 32'hc0};
    assign a_rdin = ra[1];
    assign b_rdin = rb[2];

    always #5 clk = ~clk;

    always @(posedge clk) if (clk_en) begin
        ra[0] <= a_rreq ? a_raddr + 32'h1000 : 32'h0;
        ra[1] <= ra[0];
        rb[0] <= b_rreq ? b_raddr + 32'h1000 : 32'h0;
        rb[1] <= rb[0];
        rb[2] <= rb[1];
    end

    ram_arbiter #(.N_MASTERS(3), .MODE(1), .READ_LATENCY(2)) dut_a (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_force_en(force_en), .i_force_sel(force_sel),
        .i_req(req), .i_we(we), .i_be(be_bus), .i_addr(addr_bus), .i_wdata(wdata_bus),
        .o_ack(a_ack), .o_rvalid(a_rv), .o_rdata(a_rdata),
        .o_ram_read_req(a_rreq), .o_ram_read_addr(a_raddr), .i_ram_read_data(a_rdin),
        .o_ram_write_enable(a_wen), .o_ram_byte_enable(a_be), .o_ram_write_addr(a_waddr),
        .o_ram_write_data(a_wdata)
    );

    ram_arbiter #(.N_MASTERS(3), .MODE(0), .READ_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .clk_en(clk_en), .i_force_en(force_en), .i_force_sel(force_sel),
        .i_req(req), .i_we(we), .i_be(be_bus), .i_addr(addr_bus), .i_wdata(wdata_bus),
        .o_ack(b_ack), .o_rvalid(b_rv), .o_rdata(b_rdata),
        .o_ram_read_req(b_rreq), .o_ram_read_addr(b_raddr), .i_ram_read_data(b_rdin),
        .o_ram_write_enable(b_wen), .o_ram_byte_enable(b_be), .o_ram_write_addr(b_waddr),
        .o_ram_write_data(b_wdata)
    );

    typedef struct {
        logic en, fe;
        logic [1:0] fs;
        logic [2:0] req, ack_a, ack_b;
    } vec_t;
    vec_t tv [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_addr(input logic [2:0] ack);
        return ack[1] ? 32'h200 : ack[2] ? 32'h300 : 32'h100;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1; req = 0; we = 0; clk_en = 1; force_en = 0; force_sel = 0;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        ma[0] = 32'h100; ma[1] = 32'h200; ma[2] = 32'h300;
        tv[0]  = '{1, 0, 0, 3'b111, 3'b001, 3'b001};
        tv[1]  = '{1, 0, 0, 3'b111, 3'b010, 3'b001};
        tv[2]  = '{1, 0, 0, 3'b111, 3'b100, 3'b001};
        tv[3]  = '{1, 0, 0, 3'b111, 3'b001, 3'b001};
        tv[4]  = '{1, 0, 0, 3'b111, 3'b010, 3'b001};
        tv[5]  = '{1, 0, 0, 3'b111, 3'b100, 3'b001};
        tv[6]  = '{1, 0, 0, 3'b110, 3'b010, 3'b010};
        tv[7]  = '{1, 0, 0, 3'b110, 3'b100, 3'b010};
        tv[8]  = '{1, 0, 0, 3'b110, 3'b010, 3'b010};
        tv[9]  = '{1, 1, 1, 3'b011, 3'b010, 3'b010};
        tv[10] = '{1, 1, 3, 3'b111, 3'b000, 3'b000};
        tv[11] = '{1, 1, 2, 3'b011, 3'b000, 3'b000};
        tv[12] = '{1, 0, 0, 3'b011, 3'b001, 3'b001};
        tv[13] = '{0, 0, 0, 3'b111, 3'b000, 3'b000};
        tv[14] = '{1, 0, 0, 3'b101, 3'b100, 3'b001};
        tv[15] = '{1, 0, 0, 3'b000, 3'b000, 3'b000};

        do_reset();
        #2;
        chk("reset rvalid_a", 32'(a_rv), 0);
        chk("reset rvalid_b", 32'(b_rv), 0);
        chk("reset ack_a idle", 32'(a_ack), 0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            clk_en = tv[i].en; force_en = tv[i].fe; force_sel = tv[i].fs;
            req = tv[i].req; we = 3'b111;
            #2;
            chk($sformatf("v%0d ack_a", i), 32'(a_ack), 32'(tv[i].ack_a));
            chk($sformatf("v%0d ack_b", i), 32'(b_ack), 32'(tv[i].ack_b));
            chk($sformatf("v%0d wen_a", i), 32'(a_wen), 32'(|tv[i].ack_a));
            chk($sformatf("v%0d rreq_a", i), 32'(a_rreq), 0);
            chk($sformatf("v%0d waddr_a", i), a_waddr, exp_addr(tv[i].ack_a));
            chk($sformatf("v%0d rvalid_a", i), 32'(a_rv), 0);
        end

        do_reset();
        ma[0] = 32'h10; ma[1] = 32'h20;
        @(negedge clk); req = 3'b001; we = 0; #2;
        chk("rd m0 ack", 32'(a_ack), 32'b001);
        chk("rd m0 rreq", 32'(a_rreq), 1);
        chk("rd m0 raddr", a_raddr, 32'h10);
        @(negedge clk); req = 3'b010; #2;
        chk("rd m1 ack", 32'(a_ack), 32'b010);
        chk("rd m1 raddr", a_raddr, 32'h20);
        @(negedge clk); req = 0; #2;
        chk("rd m0 rvalid", 32'(a_rv), 32'b001);
        chk("rd m0 rdata", a_rdata, 32'h1010);
        @(negedge clk); #2;
        chk("rd m1 rvalid", 32'(a_rv), 32'b010);
        chk("rd m1 rdata", a_rdata, 32'h1020);
        @(negedge clk); #2;
        chk("rd idle rvalid", 32'(a_rv), 0);

        do_reset();
        @(negedge clk); force_en = 1; force_sel = 1; req = 3'b011; we = 3'b111; #2;
        chk("force ack", 32'(a_ack), 32'b010);
        chk("force wdata", a_wdata, 32'hc1);
        @(negedge clk); force_en = 0; #2;
        chk("unforce ack", 32'(a_ack), 32'b001);

        do_reset();
        ma[0] = 32'h10;
        @(negedge clk); req = 3'b001; we = 0; #2;
        chk("rst rd ack", 32'(a_ack), 32'b001);
        @(negedge clk); rst = 1; req = 0; #2;
        chk("rst cyc rvalid", 32'(a_rv), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); rst = 0; #2;
            chk($sformatf("post rst rvalid %0d", i), 32'(a_rv), 0);
        end
        @(negedge clk); req = 3'b011; we = 3'b111; #2;
        chk("post rst ptr", 32'(a_ack), 32'b001);

        do_reset();
        ma[0] = 32'h40;
        @(negedge clk); req = 3'b001; we = 0; #2;
        chk("ce rd ack", 32'(b_ack), 32'b001);
        @(negedge clk); clk_en = 0; req = 3'b010; we = 3'b010; #2;
        chk("ce low ack", 32'(b_ack), 0);
        chk("ce low wen", 32'(b_wen), 0);
        chk("ce low rvalid", 32'(b_rv), 0);
        @(negedge clk); clk_en = 1; #2;
        chk("ce wr ack", 32'(b_ack), 32'b010);
        chk("ce c2 rvalid", 32'(b_rv), 0);
        @(negedge clk); req = 0; we = 0; #2;
        chk("ce c3 rvalid", 32'(b_rv), 0);
        @(negedge clk); #2;
        chk("ce c4 rvalid", 32'(b_rv), 32'b001);
        chk("ce c4 rdata", b_rdata, 32'h1040);
        @(negedge clk); #2;
        chk("ce c5 rvalid", 32'(b_rv), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
